// File: rtl/toi2s_pkg.sv
// Shared definitions for the toi2s I2S transmit path.
package toi2s_pkg;

  localparam int unsigned SAMPLE_W_DEF = 16;
  localparam int unsigned DIV_W_DEF    = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // Width of the frame bit index for a given slot width (frame = 2 slots).
  function automatic int unsigned idx_w(input int unsigned sample_w);
    return $clog2(2 * sample_w);
  endfunction

endpackage

// File: rtl/i2s_bclk_div.sv
// BCLK generator: half-period of div_i+1 clk cycles while enabled,
// held low with a cleared counter otherwise. First toggle after enable is rising.
module i2s_bclk_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             bclk_o,
  output logic             fall_tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;
  logic             tc;

  assign tc          = (cnt_q == div_i);
  assign fall_tick_o = en_i & tc & bclk_q;
  assign bclk_o      = bclk_q;

  // Next divider count and bclk level.
  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (tc) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Divider registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

endmodule

// File: rtl/i2s_tx_sequencer.sv
// I2S (Philips) transmit sequencer: FSM, frame index, one-pair holding
// register and frame shift register; the divider provides BCLK and fall ticks.
module i2s_tx_sequencer
  import toi2s_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned DIV_W    = DIV_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_en,
  input  logic [DIV_W-1:0]    cfg_div,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  output logic                in_ready,
  output logic                i2s_bclk,
  output logic                i2s_ws,
  output logic                i2s_sd,
  output logic                underrun,
  output logic                busy
);

  localparam int unsigned FRAME_W = 2 * SAMPLE_W;
  localparam int unsigned IDX_W   = idx_w(SAMPLE_W);

  seq_state_e         state_q, state_d;
  logic [DIV_W-1:0]   div_l_q, div_l_d;
  logic               hold_full_q, hold_full_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic [FRAME_W-1:0] act_q, act_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic               ws_q, ws_d;
  logic               sd_q, sd_d;
  logic               ur_q, ur_d;

  logic run_en;
  logic fall_tick;
  logic load_tick;
  logic accept;

  // Dropping cfg_en takes effect at the very next edge, so the datapath
  // treats the last RUN cycle with cfg_en=0 as already idle.
  assign run_en    = (state_q == ST_RUN) & cfg_en;
  assign in_ready  = ~hold_full_q & ~rst;
  assign accept    = in_valid & in_ready;
  assign load_tick = fall_tick & (k_q == '0);

  assign i2s_ws   = ws_q;
  assign i2s_sd   = sd_q;
  assign underrun = ur_q;
  assign busy     = (state_q == ST_RUN);

  i2s_bclk_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .en_i        (run_en),
    .div_i       (div_l_q),
    .bclk_o      (i2s_bclk),
    .fall_tick_o (fall_tick)
  );

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cfg_en)  state_d = ST_RUN;
      ST_RUN:  if (!cfg_en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next state: divider latch, holding register, frame serialiser.
  always_comb begin
    div_l_d     = div_l_q;
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    act_d       = act_q;
    k_d         = k_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    ur_d        = 1'b0;

    if ((state_q == ST_IDLE) && cfg_en) div_l_d = cfg_div;

    // The k=0 tick drains the holding register; a same-cycle handshake with
    // holding empty bypasses straight into the shift register.
    if (load_tick) begin
      hold_full_d = 1'b0;
    end else if (accept) begin
      hold_full_d = 1'b1;
      hold_d      = {in_left, in_right};
    end

    if (!run_en) begin
      act_d = '0;
      k_d   = '0;
      ws_d  = 1'b0;
      sd_d  = 1'b0;
    end else if (fall_tick) begin
      ws_d = (k_q >= IDX_W'(SAMPLE_W));
      // After 2W-1 shifts the MSB position holds the previous R LSB, which
      // is exactly the bit due at k=0.
      sd_d = act_q[FRAME_W-1];
      k_d  = (k_q == IDX_W'(FRAME_W - 1)) ? '0 : k_q + 1'b1;
      if (k_q == '0) begin
        if (hold_full_q) begin
          act_d = hold_q;
        end else if (accept) begin
          act_d = {in_left, in_right};
        end else begin
          act_d = '0;
          ur_d  = 1'b1;
        end
      end else begin
        act_d = {act_q[FRAME_W-2:0], 1'b0};
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_l_q     <= '0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      act_q       <= '0;
      k_q         <= '0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_l_q     <= div_l_d;
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
      act_q       <= act_d;
      k_q         <= k_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      ur_q        <= ur_d;
    end
  end

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Directed bench for i2s_tx_sequencer with a frame decoder and pair scoreboard.
module tb_i2s_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b0;
  logic [7:0]  cfg_div = 8'd1;
  logic        in_valid = 1'b0;
  logic [15:0] in_left = '0;
  logic [15:0] in_right = '0;
  logic        in_ready, i2s_bclk, i2s_ws, i2s_sd, underrun, busy;

  always #5 clk = ~clk;

  i2s_tx_sequencer #(
    .SAMPLE_W (16),
    .DIV_W    (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_en   (cfg_en),
    .cfg_div  (cfg_div),
    .in_valid (in_valid),
    .in_left  (in_left),
    .in_right (in_right),
    .in_ready (in_ready),
    .i2s_bclk (i2s_bclk),
    .i2s_ws   (i2s_ws),
    .i2s_sd   (i2s_sd),
    .underrun (underrun),
    .busy     (busy)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [63:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  logic [31:0] dec_q[$];

  // Monitor: underrun pulses and I2S receiver sampling sd/ws on bclk rises.
  int          ur_cnt = 0;
  logic [63:0] ur_last = '0, ur_prev = '0;
  logic [63:0] rise_last = '0, rise_prev = '0;
  int          rise_cnt = 0;
  logic        first_sd = 1'b0, first_ws = 1'b0;
  logic        prev_bclk = 1'b0, prev_ws = 1'b0, have_left = 1'b0;
  logic [15:0] sr = '0, left_w = '0;

  always @(negedge clk) begin
    if (underrun) begin
      ur_cnt  = ur_cnt + 1;
      ur_prev = ur_last;
      ur_last = cyc;
    end
    if (!busy) begin
      prev_ws   = 1'b0;
      have_left = 1'b0;
      sr        = '0;
      rise_cnt  = 0;
    end else if (i2s_bclk && !prev_bclk) begin
      rise_prev = rise_last;
      rise_last = cyc;
      if (rise_cnt == 0) begin
        first_sd = i2s_sd;
        first_ws = i2s_ws;
      end
      rise_cnt = rise_cnt + 1;
      sr = {sr[14:0], i2s_sd};
      if (i2s_ws != prev_ws) begin
        if (i2s_ws) begin
          left_w    = sr;
          have_left = 1'b1;
        end else if (have_left) begin
          dec_q.push_back({left_w, sr});
          have_left = 1'b0;
        end
      end
      prev_ws = i2s_ws;
    end
    prev_bclk = i2s_bclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dec(input string tag);
    int c = 0;
    while (dec_q.size() == 0 && c < 700) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_decode_timeout"}, 64'(dec_q.size() > 0), 64'd1);
  endtask

  task automatic expect_pair(input string tag);
    wait_dec(tag);
    if (dec_q.size() > 0 && exp_q.size() > 0)
      check(tag, 64'(dec_q.pop_front()), 64'(exp_q.pop_front()));
  endtask

  // Offers a pair from a negedge and returns on the negedge after the handshake.
  task automatic push_pair(input logic [15:0] l, input logic [15:0] r,
                           input logic ready_after, input string tag);
    int c = 0;
    in_left  = l;
    in_right = r;
    in_valid = 1'b1;
    while (!in_ready && c < 700) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back({l, r});
    check({tag, "_ready_after_accept"}, 64'(in_ready), 64'(ready_after));
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_ready);
    check({tag, "_bclk"},     64'(i2s_bclk), 64'd0);
    check({tag, "_ws"},       64'(i2s_ws),   64'd0);
    check({tag, "_sd"},       64'(i2s_sd),   64'd0);
    check({tag, "_underrun"}, 64'(underrun), 64'd0);
    check({tag, "_busy"},     64'(busy),     64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(exp_ready));
  endtask

  int u0;
  int c;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 1'b0);
    rst = 1'b0;
    #1;
    check("reset_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Preloaded pair, first frames, divider period
    push_pair(16'hA5F0, 16'h0F3C, 1'b0, "preload");
    cfg_div = 8'd1;
    cfg_en  = 1'b1;
    u0 = ur_cnt;
    @(posedge clk);
    #1;
    check("busy_after_enable", 64'(busy), 64'd1);
    expect_pair("pair_A5F0_0F3C");
    check("first_k0_sd", 64'(first_sd), 64'd0);
    check("first_k0_ws", 64'(first_ws), 64'd0);
    check("underruns_after_first_frame", 64'(ur_cnt - u0), 64'd1);
    check("bclk_period_div1", rise_last - rise_prev, 64'd4);

    // Starved: zero frames, one underrun per 128 clk
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    expect_pair("underrun_frame_1");
    expect_pair("underrun_frame_2");
    check("underrun_count", 64'(ur_cnt - u0), 64'd3);
    check("underrun_interval", ur_last - ur_prev, 64'd128);
    check("busy_while_starved", 64'(busy), 64'd1);
    cfg_en = 1'b0;
    repeat (2) @(negedge clk);
    dec_q.delete();
    exp_q.delete();

    // Streaming four pairs with the source always valid
    u0 = ur_cnt;
    push_pair(16'h1234, 16'h8765, 1'b0, "stream0");
    cfg_en = 1'b1;
    push_pair(16'hFFFF, 16'h0001, 1'b0, "stream1");
    push_pair(16'h8000, 16'h7FFF, 1'b0, "stream2");
    push_pair(16'hC3C3, 16'h5A5A, 1'b0, "stream3");
    for (int i = 0; i < 4; i++) begin
      expect_pair($sformatf("stream_pair%0d", i));
      if (i == 2) check("stream_no_underrun", 64'(ur_cnt - u0), 64'd0);
    end
    cfg_en = 1'b0;
    repeat (2) @(negedge clk);
    dec_q.delete();
    exp_q.delete();

    // Bypass: handshake exactly on the second frame's k=0 tick
    cfg_en = 1'b1;
    exp_q.push_back(32'h0);
    c = 0;
    @(negedge clk);
    while (!underrun && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("bypass_first_underrun", 64'(underrun), 64'd1);
    repeat (127) @(negedge clk);
    in_left  = 16'hBEEF;
    in_right = 16'h1357;
    in_valid = 1'b1;
    check("bypass_ready_at_tick", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back({16'hBEEF, 16'h1357});
    check("bypass_holding_stays_empty", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("bypass_no_underrun", 64'(underrun), 64'd0);
    expect_pair("bypass_zero_frame");
    expect_pair("bypass_pair");
    cfg_en = 1'b0;
    repeat (2) @(negedge clk);
    dec_q.delete();
    exp_q.delete();

    // Disable mid-frame with a held pair, then resume
    push_pair(16'h0F0F, 16'hF0F0, 1'b0, "midstop_active");
    cfg_en = 1'b1;
    push_pair(16'h6C6C, 16'h9393, 1'b0, "midstop_held");
    repeat (34) @(negedge clk);
    cfg_en = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("midstop", 1'b0);
    dec_q.delete();
    exp_q.delete();
    exp_q.push_back({16'h6C6C, 16'h9393});
    @(negedge clk);
    cfg_en = 1'b1;
    expect_pair("resume_held_pair");

    // Reset mid-frame with holding full, then slower divider
    push_pair(16'hDEAD, 16'hD00D, 1'b0, "prereset");
    repeat (20) @(negedge clk);
    rst     = 1'b1;
    cfg_en  = 1'b0;
    cfg_div = 8'd3;
    @(posedge clk);
    #1;
    check_idle_outputs("midreset", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midreset_holding_discarded", 64'(in_ready), 64'd1);
    dec_q.delete();
    exp_q.delete();
    @(negedge clk);
    push_pair(16'h2468, 16'hACE0, 1'b0, "div3");
    cfg_en = 1'b1;
    expect_pair("div3_pair");
    check("bclk_period_div3", rise_last - rise_prev, 64'd8);
    cfg_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
